// File: rtl/seg_text_scroller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg_text_scroller_if : character load stream for seg_text_scroller     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface seg_text_scroller_if;
  logic       load_start;
  logic       char_valid;
  logic [5:0] char_in;
  logic       char_ready;
  logic       load_done;

  modport master (
    output load_start,
    output char_valid,
    output char_in,
    output load_done,
    input  char_ready
  );

  modport slave (
    input  load_start,
    input  char_valid,
    input  char_in,
    input  load_done,
    output char_ready
  );
endinterface
`default_nettype wire

// File: rtl/seg_text_scroller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seg_text_scroller : message buffer + scrolling 8-digit window (p0..p7) |
// | Optional macro SCROLL_PAUSE_EN adds a `pause` input. Rev 1.0           |
// +-----------------------------------------------------------------------+
module seg_text_scroller #(
  parameter int         MAX_LEN     = 16,
  parameter int         GAP         = 3,
  parameter int         STEP_CYCLES = 50_000_000,
  parameter logic [5:0] BLANK_CODE  = 6'd63
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SCROLL_PAUSE_EN
  input  logic                 pause,
`endif
  seg_text_scroller_if.slave   s,
  output logic                 scrolling,
  output logic                 wrap,
  output logic [5:0]           p0,
  output logic [5:0]           p1,
  output logic [5:0]           p2,
  output logic [5:0]           p3,
  output logic [5:0]           p4,
  output logic [5:0]           p5,
  output logic [5:0]           p6,
  output logic [5:0]           p7
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = $clog2(MAX_LEN + GAP + 8);
  localparam int SW = $clog2(STEP_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;

  localparam logic [LW-1:0] MAX_L     = LW'(MAX_LEN);
  localparam logic [LW-1:0] STATIC_L  = LW'(8);
  localparam logic [PW-1:0] GAP_P     = PW'(GAP);
  localparam logic [PW-1:0] ONE_P     = PW'(1);
  localparam logic [SW-1:0] ONE_S     = SW'(1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          wrap_q, wrap_d;
  logic [5:0]    p_q [8];
  logic [5:0]    p_d [8];
  logic [5:0]    char_mem [MAX_LEN];

  logic          xfer;
  logic          run;
  logic          scroll_mode;
  logic [LW-1:0] wr_cnt;
  logic [PW-1:0] len_p;
  logic [PW-1:0] period;

`ifdef SCROLL_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  assign s.char_ready = (state_q == S_LOAD) && (wr_ptr_q < MAX_L);
  // A load_start in the same cycle discards the buffer, so no write happens
  assign xfer         = s.char_valid && s.char_ready && !s.load_start;
  assign wr_cnt       = wr_ptr_q + {{(LW-1){1'b0}}, xfer};
  assign scroll_mode  = (len_q > STATIC_L);
  assign scrolling    = (state_q == S_SHOW) && scroll_mode;
  assign wrap         = wrap_q;
  assign len_p        = PW'(len_q);
  assign period       = len_p + GAP_P;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_ptr_d   = wr_ptr_q;
    pos_d      = pos_q;
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;
    if (s.load_start) begin
      state_d    = S_LOAD;
      wr_ptr_d   = '0;
      pos_d      = '0;
      step_cnt_d = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          wr_ptr_d = wr_cnt;
          if (s.load_done) begin
            if (wr_cnt == '0) begin
              state_d = S_IDLE;
            end else begin
              len_d   = wr_cnt;
              state_d = S_SHOW;
            end
          end
        end
        S_SHOW: begin
          if (scroll_mode && run) begin
            if (step_cnt_q == STEP_LAST) begin
              step_cnt_d = '0;
              if (pos_q == period - ONE_P) begin
                pos_d  = '0;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q + ONE_P;
              end
            end else begin
              step_cnt_d = step_cnt_q + ONE_S;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // pos < period and period >= 12 when scrolling, so one subtract is a full modulo;
  // in the static case pos is 0 and the raw index already blanks digits len..7.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    logic [PW-1:0] idx_raw;
    logic [PW-1:0] idx;
    assign idx_raw = pos_q + PW'(gi);
    assign idx     = (scroll_mode && (idx_raw >= period)) ? (idx_raw - period) : idx_raw;
    assign p_d[gi] = (!s.load_start && (state_q == S_SHOW) && (idx < len_p))
                     ? char_mem[idx[AW-1:0]] : BLANK_CODE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      pos_q      <= '0;
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
      for (int i = 0; i < 8; i++) p_q[i] <= BLANK_CODE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      pos_q      <= pos_d;
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
      for (int i = 0; i < 8; i++) p_q[i] <= p_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) char_mem[wr_ptr_q[AW-1:0]] <= s.char_in;
  end

  assign p0 = p_q[0];
  assign p1 = p_q[1];
  assign p2 = p_q[2];
  assign p3 = p_q[3];
  assign p4 = p_q[4];
  assign p5 = p_q[5];
  assign p6 = p_q[6];
  assign p7 = p_q[7];
endmodule
`default_nettype wire

// File: tb/tb_seg_text_scroller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_seg_text_scroller : directed/random bench with a queue-based model  |
// | Pause steps compiled only with SCROLL_PAUSE_EN. Rev 1.0                |
// +-----------------------------------------------------------------------+
module tb_seg_text_scroller;
  localparam int MAX_LEN = 16;
  localparam int GAP     = 3;
  localparam int STEP    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_text_scroller_if sif();
  logic       scrolling, wrap;
  logic [5:0] p0, p1, p2, p3, p4, p5, p6, p7;
`ifdef SCROLL_PAUSE_EN
  logic       pause = 1'b0;
`endif

  seg_text_scroller #(
    .MAX_LEN(MAX_LEN), .GAP(GAP), .STEP_CYCLES(STEP), .BLANK_CODE(6'd63)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef SCROLL_PAUSE_EN
    .pause(pause),
`endif
    .s(sif),
    .scrolling(scrolling),
    .wrap(wrap),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .p4(p4), .p5(p5), .p6(p6), .p7(p7)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] msg[$];   // characters the model believes are buffered
  logic [5:0] src[$];   // characters offered on the stream
  int k;                // active SHOW edges since the load_done edge
  int last_wrap;
  int wrap_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic logic [5:0] exp_digit(input int pos, input int i);
    int l, idx;
    l = msg.size();
    if (l <= 8) return (i < l) ? msg[i] : 6'd63;
    idx = (pos + i) % (l + GAP);
    return (idx < l) ? msg[idx] : 6'd63;
  endfunction

  task automatic check_frame(input int pos, input string tag);
    logic [5:0] a [8];
    a = '{p0, p1, p2, p3, p4, p5, p6, p7};
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s pos%0d p%0d", tag, pos, i), 32'(a[i]), 32'(exp_digit(pos, i)));
  endtask

  // Pulse load_start, stream src with char_valid held, then commit.
  task automatic do_load(input bit done_with_last);
    sif.load_start = 1'b1;
    tick();
    sif.load_start = 1'b0;
    msg.delete();
    for (int j = 0; j < src.size(); j++) begin
      sif.char_valid = 1'b1;
      sif.char_in    = src[j];
      if (done_with_last && j == src.size() - 1) sif.load_done = 1'b1;
      chk("char_ready", 32'(sif.char_ready), 32'(msg.size() < MAX_LEN));
      if (msg.size() < MAX_LEN) msg.push_back(src[j]);
      tick();
    end
    sif.char_valid = 1'b0;
    if (!done_with_last) begin
      sif.load_done = 1'b1;
      tick();
    end
    sif.load_done = 1'b0;
    k         = 0;
    last_wrap = -1;
    wrap_cnt  = 0;
  endtask

  // Frames sampled mid-step so a one-edge output latency cannot matter.
  task automatic run_show(input int n, input string tag);
    int l, per;
    l   = msg.size();
    per = STEP * (l + GAP);
    for (int c = 0; c < n; c++) begin
      tick();
      k++;
      chk({tag, " scrolling"}, 32'(scrolling), 32'(l > 8));
      if (l <= 8) begin
        chk({tag, " no wrap"}, 32'(wrap), 32'd0);
        if (k >= 2) check_frame(0, tag);
      end else if ((k - 1) % STEP == 2) begin
        check_frame(((k - 1) / STEP) % (l + GAP), tag);
      end
      if (wrap === 1'b1) begin
        if (last_wrap >= 0) chk({tag, " wrap spacing"}, k - last_wrap, per);
        last_wrap = k;
        wrap_cnt++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    sif.load_start = 1'b0;
    sif.char_valid = 1'b0;
    sif.char_in    = '0;
    sif.load_done  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("reset char_ready", 32'(sif.char_ready), 32'd0);
    chk("reset scrolling", 32'(scrolling), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    check_frame(0, "reset");

    // static message 1,2,3
    src = '{6'd1, 6'd2, 6'd3};
    do_load(1'b0);
    run_show(100, "static3");
    chk("static3 wrap count", wrap_cnt, 0);

    // ten characters scroll, period 13 steps
    src.delete();
    for (int j = 1; j <= 10; j++) src.push_back(6'(j));
    do_load(1'b0);
    run_show(2 * STEP * 13 + 10, "scroll10");
    chk("scroll10 wrap count", wrap_cnt, 2);

    // random length/content scroll
    n = $urandom_range(9, MAX_LEN);
    src.delete();
    for (int j = 0; j < n; j++) src.push_back(6'($urandom_range(0, 62)));
    do_load(1'b0);
    run_show(2 * STEP * (n + GAP) + 10, "scroll_rand");
    chk("scroll_rand wrap count", wrap_cnt, 2);

    // overfill: 20 offered, 16 kept
    src.delete();
    for (int j = 0; j < 20; j++) src.push_back(6'($urandom_range(0, 62)));
    do_load(1'b0);
    run_show(2 * STEP * (MAX_LEN + GAP) + 10, "full");
    chk("full wrap count", wrap_cnt, 2);

    // load_start beats load_done during SHOW
    sif.load_start = 1'b1;
    sif.load_done  = 1'b1;
    tick();
    sif.load_start = 1'b0;
    sif.load_done  = 1'b0;
    msg.delete();
    chk("prio char_ready", 32'(sif.char_ready), 32'd1);
    chk("prio scrolling", 32'(scrolling), 32'd0);
    check_frame(0, "prio blank");

    // last character arrives together with load_done
    src.delete();
    for (int j = 0; j < 3; j++) src.push_back(6'($urandom_range(0, 62)));
    do_load(1'b1);
    run_show(20, "done_with_char");

    // empty load returns to IDLE; char_valid ignored there
    sif.load_start = 1'b1;
    tick();
    sif.load_start = 1'b0;
    sif.load_done  = 1'b1;
    tick();
    sif.load_done  = 1'b0;
    msg.delete();
    sif.char_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("idle char_ready", 32'(sif.char_ready), 32'd0);
      chk("idle scrolling", 32'(scrolling), 32'd0);
    end
    sif.char_valid = 1'b0;
    check_frame(0, "idle");

`ifdef SCROLL_PAUSE_EN
    src.delete();
    for (int j = 0; j < 12; j++) src.push_back(6'($urandom_range(0, 62)));
    do_load(1'b0);
    run_show(31, "pre_pause");
    pause = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      check_frame(((k - 1) / STEP) % (12 + GAP), "paused");
    end
    pause = 1'b0;
    run_show(40, "post_pause");
    chk("pause wrap count", wrap_cnt, 1);
`endif

    // asynchronous reset mid-scroll
    src.delete();
    for (int j = 1; j <= 10; j++) src.push_back(6'(j));
    do_load(1'b0);
    run_show(30, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    msg.delete();
    chk("async rst char_ready", 32'(sif.char_ready), 32'd0);
    chk("async rst scrolling", 32'(scrolling), 32'd0);
    chk("async rst wrap", 32'(wrap), 32'd0);
    check_frame(0, "async rst");
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
